// File: rtl/fsm_traffic_controller.sv
// Single-approach traffic-light sequencer: Moore FSM RED -> GREEN -> YELLOW -> RED with per-phase timers.
// Optional RED_YELLOW phase between RED and GREEN when FSM_RED_YELLOW_EN is defined.
module fsm_traffic_controller #(
    parameter int RED_TIME    = 5,
    parameter int GREEN_TIME  = 4,
    parameter int YELLOW_TIME = 2,
    parameter int RY_TIME     = 1,
    parameter int CNT_W       = 8
) (
    input  logic       clock,
    input  logic       reset,
    output logic [2:0] light
);

    localparam longint MAX_DUR = longint'(1) << CNT_W;

`ifdef FSM_RED_YELLOW_EN
    localparam int N_DUR = 4;
    localparam longint DUR_TAB [N_DUR] = '{RED_TIME, GREEN_TIME, YELLOW_TIME, RY_TIME};
`else
    localparam int N_DUR = 3;
    localparam longint DUR_TAB [N_DUR] = '{RED_TIME, GREEN_TIME, YELLOW_TIME};
`endif

    // Durations outside 1..2^CNT_W cannot be counted by the phase timer.
    generate
        for (genvar gi = 0; gi < N_DUR; gi++) begin : g_dur_check
            if (DUR_TAB[gi] < 1 || DUR_TAB[gi] > MAX_DUR) begin : g_bad
                $error("fsm_traffic_controller: phase duration %0d out of range 1..%0d",
                       DUR_TAB[gi], MAX_DUR);
            end
        end
`ifndef FSM_RED_YELLOW_EN
        if (RY_TIME != 1) begin : g_ry_ignored
            $info("fsm_traffic_controller: RY_TIME ignored without FSM_RED_YELLOW_EN");
        end
`endif
    endgenerate

    // Terminal timer values; a duration of 2^CNT_W terminates at all-ones.
    localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(RED_TIME - 1);
    localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TIME - 1);
    localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TIME - 1);
`ifdef FSM_RED_YELLOW_EN
    localparam logic [CNT_W-1:0] RY_LAST     = CNT_W'(RY_TIME - 1);
`endif

`ifdef FSM_RED_YELLOW_EN
    typedef enum logic [1:0] {
        RED        = 2'd0,
        GREEN      = 2'd1,
        YELLOW     = 2'd2,
        RED_YELLOW = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RED;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_next = timer + 1'b1;
        case (state)
            RED: begin
                if (timer == RED_LAST) begin
`ifdef FSM_RED_YELLOW_EN
                    state_next = RED_YELLOW;
`else
                    state_next = GREEN;
`endif
                    timer_next = '0;
                end
            end
`ifdef FSM_RED_YELLOW_EN
            RED_YELLOW: begin
                if (timer == RY_LAST) begin
                    state_next = GREEN;
                    timer_next = '0;
                end
            end
`endif
            GREEN: begin
                if (timer == GREEN_LAST) begin
                    state_next = YELLOW;
                    timer_next = '0;
                end
            end
            YELLOW: begin
                if (timer == YELLOW_LAST) begin
                    state_next = RED;
                    timer_next = '0;
                end
            end
            // Unreachable encodings recover to the start of RED on the next edge.
            default: begin
                state_next = RED;
                timer_next = '0;
            end
        endcase
    end

    // Lamp bus {red, yellow, green}, decoded from state only.
    always_comb begin
        light = 3'b100;
        case (state)
            RED:        light = 3'b100;
            GREEN:      light = 3'b001;
            YELLOW:     light = 3'b010;
`ifdef FSM_RED_YELLOW_EN
            RED_YELLOW: light = 3'b110;
`endif
            default:    light = 3'b100;
        endcase
    end

endmodule

// File: tb/tb_fsm_traffic_controller.sv
// Directed bench for fsm_traffic_controller: default timing instance plus an all-ones-duration instance.
// Follows FSM_RED_YELLOW_EN for its expected values.
module tb_fsm_traffic_controller;

    logic       clock  = 1'b0;
    logic       reset  = 1'b0;
    logic       clk_en = 1'b0;
    logic [2:0] light;
    logic [2:0] light_min;

    int vec_cnt = 0;
    int err_cnt = 0;

    fsm_traffic_controller dut (
        .clock (clock),
        .reset (reset),
        .light (light)
    );

    fsm_traffic_controller #(
        .RED_TIME    (1),
        .GREEN_TIME  (1),
        .YELLOW_TIME (1),
        .RY_TIME     (1)
    ) dut_min (
        .clock (clock),
        .reset (reset),
        .light (light_min)
    );

    always #5 if (clk_en) clock = ~clock;

    typedef struct {
        logic       rst;
        logic [2:0] exp_main;
        logic [2:0] exp_min;
    } vec_t;

    localparam int N_VEC = 23;
    vec_t vt [N_VEC];

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: light=%b required=%b", name, got, exp);
        end else begin
            $display("ok   %s: light=%b", name, got);
        end
    endtask

    task automatic check_legal(input string name, input logic [2:0] got);
        logic ok;
`ifdef FSM_RED_YELLOW_EN
        ok = !$isunknown(got) && (got == 3'b100 || got == 3'b001 || got == 3'b010 || got == 3'b110);
`else
        ok = !$isunknown(got) && (got == 3'b100 || got == 3'b001 || got == 3'b010);
`endif
        vec_cnt++;
        if (!ok) begin
            err_cnt++;
            $display("FAIL %s: light=%b required=legal lamp pattern", name, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reset pulse placed between edges; light must drop to RED before any edge.
    task automatic pulse_reset(input string name);
        reset = 1'b1;
        #1;
        check({name, "_main"}, light, 3'b100);
        check({name, "_min"}, light_min, 3'b100);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Table row 0 holds reset; rows 1..22 are rising edges after release.
`ifdef FSM_RED_YELLOW_EN
        vt[0]  = '{1'b1, 3'b100, 3'b100};
        vt[1]  = '{1'b0, 3'b100, 3'b110};
        vt[2]  = '{1'b0, 3'b100, 3'b001};
        vt[3]  = '{1'b0, 3'b100, 3'b010};
        vt[4]  = '{1'b0, 3'b100, 3'b100};
        vt[5]  = '{1'b0, 3'b110, 3'b110};
        vt[6]  = '{1'b0, 3'b001, 3'b001};
        vt[7]  = '{1'b0, 3'b001, 3'b010};
        vt[8]  = '{1'b0, 3'b001, 3'b100};
        vt[9]  = '{1'b0, 3'b001, 3'b110};
        vt[10] = '{1'b0, 3'b010, 3'b001};
        vt[11] = '{1'b0, 3'b010, 3'b010};
        vt[12] = '{1'b0, 3'b100, 3'b100};
        vt[13] = '{1'b0, 3'b100, 3'b110};
        vt[14] = '{1'b0, 3'b100, 3'b001};
        vt[15] = '{1'b0, 3'b100, 3'b010};
        vt[16] = '{1'b0, 3'b100, 3'b100};
        vt[17] = '{1'b0, 3'b110, 3'b110};
        vt[18] = '{1'b0, 3'b001, 3'b001};
        vt[19] = '{1'b0, 3'b001, 3'b010};
        vt[20] = '{1'b0, 3'b001, 3'b100};
        vt[21] = '{1'b0, 3'b001, 3'b110};
        vt[22] = '{1'b0, 3'b010, 3'b001};
`else
        vt[0]  = '{1'b1, 3'b100, 3'b100};
        vt[1]  = '{1'b0, 3'b100, 3'b001};
        vt[2]  = '{1'b0, 3'b100, 3'b010};
        vt[3]  = '{1'b0, 3'b100, 3'b100};
        vt[4]  = '{1'b0, 3'b100, 3'b001};
        vt[5]  = '{1'b0, 3'b001, 3'b010};
        vt[6]  = '{1'b0, 3'b001, 3'b100};
        vt[7]  = '{1'b0, 3'b001, 3'b001};
        vt[8]  = '{1'b0, 3'b001, 3'b010};
        vt[9]  = '{1'b0, 3'b010, 3'b100};
        vt[10] = '{1'b0, 3'b010, 3'b001};
        vt[11] = '{1'b0, 3'b100, 3'b010};
        vt[12] = '{1'b0, 3'b100, 3'b100};
        vt[13] = '{1'b0, 3'b100, 3'b001};
        vt[14] = '{1'b0, 3'b100, 3'b010};
        vt[15] = '{1'b0, 3'b100, 3'b100};
        vt[16] = '{1'b0, 3'b001, 3'b001};
        vt[17] = '{1'b0, 3'b001, 3'b010};
        vt[18] = '{1'b0, 3'b001, 3'b100};
        vt[19] = '{1'b0, 3'b001, 3'b001};
        vt[20] = '{1'b0, 3'b010, 3'b010};
        vt[21] = '{1'b0, 3'b010, 3'b100};
        vt[22] = '{1'b0, 3'b100, 3'b001};
`endif

        // Reset with the clock stopped: light must be RED without any edge.
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_main", light, 3'b100);
        check("async_reset_min", light_min, 3'b100);
        #1;
        reset  = 1'b0;
        #1;
        check("released_noclk_main", light, 3'b100);
        clk_en = 1'b1;

        // Row 0 re-applies reset across an edge, then edges 1..22 follow.
        for (int i = 0; i < N_VEC; i++) begin
            reset = vt[i].rst;
            tick();
            check($sformatf("table_e%0d_main", i), light, vt[i].exp_main);
            check($sformatf("table_e%0d_min", i), light_min, vt[i].exp_min);
        end

        // Restart cleanly, run to edge 7 (GREEN), then abort the phase with a reset pulse.
        pulse_reset("restart");
        for (int e = 1; e <= 7; e++) tick();
        check("midphase_e7_main", light, 3'b001);
        pulse_reset("midphase_pulse");
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("midphase_red_e%0d", e), light, 3'b100);
        end
        tick();
`ifdef FSM_RED_YELLOW_EN
        check("midphase_e5_main", light, 3'b110);
`else
        check("midphase_e5_main", light, 3'b001);
`endif

        // Free-running invariant on both instances.
        for (int c = 0; c < 200; c++) begin
            tick();
            check_legal($sformatf("inv_main_c%0d", c), light);
            check_legal($sformatf("inv_min_c%0d", c), light_min);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
